// File: rtl/sha_digest_finalize_if.sv
// Handshake and data bundle for the SHA-2 feed-forward stage.
// master drives request/ready; slave is the finalize block.
interface sha_digest_finalize_if #(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 8
);
  logic                        mode;
  logic                        trunc;
  logic                        start;
  logic                        last_block;
  logic [NUM_WORDS*WORD_W-1:0] h_in;
  logic [NUM_WORDS*WORD_W-1:0] w_in;
  logic                        busy;
  logic                        chain_valid;
  logic [NUM_WORDS*WORD_W-1:0] chain_o;
  logic                        dout_valid;
  logic                        dout_ready;
  logic [NUM_WORDS*WORD_W-1:0] digest_o;

  modport master (
    output mode, trunc, start, last_block, h_in, w_in, dout_ready,
    input  busy, chain_valid, chain_o, dout_valid, digest_o
  );

  modport slave (
    input  mode, trunc, start, last_block, h_in, w_in, dout_ready,
    output busy, chain_valid, chain_o, dout_valid, digest_o
  );
endinterface

// File: rtl/sha_digest_finalize.sv
// SHA-2 feed-forward: word-serial H + A..H over LANES adders, shared by SHA-256/512.
// Optional macro SHA_TRUNC_EN zeroes trailing digest words for SHA-224/384.
//
// state | meaning
// IDLE  | waiting for start; busy = 0
// ADD   | LANES words summed per edge into result
// CHAIN | one-cycle chain_valid pulse, back to IDLE
// OUT   | dout_valid held until dout_ready
module sha_digest_finalize #(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 8,
  parameter int LANES     = 2
) (
  input logic                clk,
  input logic                rst,
  sha_digest_finalize_if.slave bus
);
  localparam int TOT_W = NUM_WORDS * WORD_W;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [WORD_W-1:0] LO_MASK = WORD_W'(32'hFFFF_FFFF);

  typedef enum logic [1:0] {IDLE, ADD, CHAIN, OUT} state_t;

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   h_snap, w_snap, result;
  logic               mode_q, last_q;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;
  logic [WORD_W-1:0]  lane_sum [LANES];

  assign last_step = (cnt == CNT_W'(NUM_WORDS - LANES));

  always_comb begin
    state_d         = state_q;
    bus.busy        = (state_q != IDLE);
    bus.chain_valid = (state_q == CHAIN);
    bus.dout_valid  = (state_q == OUT);
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (last_step) state_d = last_q ? OUT : CHAIN;
      CHAIN:   state_d = IDLE;
      OUT:     if (bus.dout_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full-width add then mask: the low 32 bits are the mod-2^32 sum either way.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_sum[l] = h_snap[(NUM_WORDS-1-(int'(cnt)+l))*WORD_W +: WORD_W]
                  + w_snap[(NUM_WORDS-1-(int'(cnt)+l))*WORD_W +: WORD_W];
      if (!mode_q) lane_sum[l] = lane_sum[l] & LO_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h_snap  <= '0;
      w_snap  <= '0;
      result  <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        h_snap <= bus.h_in;
        w_snap <= bus.w_in;
        mode_q <= (WORD_W > 32) ? bus.mode : 1'b0;
        last_q <= bus.last_block;
        cnt    <= '0;
      end
      if (state_q == ADD) begin
        for (int l = 0; l < LANES; l++)
          result[(NUM_WORDS-1-(int'(cnt)+l))*WORD_W +: WORD_W] <= lane_sum[l];
        cnt <= last_step ? '0 : cnt + CNT_W'(LANES);
      end
    end
  end

  assign bus.chain_o = result;

`ifdef SHA_TRUNC_EN
  logic             trunc_q;
  logic [TOT_W-1:0] digest_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            trunc_q <= 1'b0;
    else if (state_q == IDLE && bus.start) trunc_q <= bus.trunc;
  end

  // SHA-224 drops the last word, SHA-384 the last two.
  always_comb begin
    digest_mask = '1;
    for (int i = 0; i < NUM_WORDS; i++)
      if (trunc_q && (i == NUM_WORDS-1 || (mode_q && i == NUM_WORDS-2)))
        digest_mask[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = '0;
  end

  assign bus.digest_o = result & digest_mask;
`else
  assign bus.digest_o = result;
`endif
endmodule

// File: tb/tb_sha_digest_finalize.sv
// Directed bench for sha_digest_finalize (WORD_W=64, NUM_WORDS=8, LANES=2).
module tb_sha_digest_finalize;
  logic clk, rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [511:0] h, w, exp_d, held;

  sha_digest_finalize_if #(.WORD_W(64), .NUM_WORDS(8)) bus ();
  sha_digest_finalize #(.WORD_W(64), .NUM_WORDS(8), .LANES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic handshake();
    bus.dout_ready = 1'b1;
    step(1);
    bus.dout_ready = 1'b0;
  endtask

  function automatic logic [511:0] rep(input logic [63:0] v);
    return {8{v}};
  endfunction

  initial begin
    rst = 1'b1;
    bus.mode = 0; bus.trunc = 0; bus.start = 0; bus.last_block = 0;
    bus.h_in = '0; bus.w_in = '0; bus.dout_ready = 0;
    step(2);
    check("rst_busy", bus.busy, 0);
    check("rst_chain_valid", bus.chain_valid, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_chain_o", bus.chain_o, 0);
    check("rst_digest_o", bus.digest_o, 0);
    rst = 1'b0;
    step(1);

    // 1: 32-bit wrap, early ready has no effect
    bus.mode = 0; bus.last_block = 1;
    bus.h_in = rep(64'hFFFF_FFFF); bus.w_in = rep(64'h1);
    bus.dout_ready = 1'b1;
    step(1);
    check("early_ready_busy", bus.busy, 0);
    bus.dout_ready = 1'b0;
    go();
    check("t1_busy_after_start", bus.busy, 1);
    step(3);
    check("t1_not_yet_valid", bus.dout_valid, 0);
    step(1);
    check("t1_dout_valid", bus.dout_valid, 1);
    check("t1_digest", bus.digest_o, 0);
    handshake();
    check("t1_idle_busy", bus.busy, 0);
    check("t1_idle_dout_valid", bus.dout_valid, 0);

    // 2: 512 carry isolation
    bus.mode = 1; bus.h_in = rep(64'hFFFF_FFFF_FFFF_FFFF); bus.w_in = rep(64'h2);
    go(); step(4);
    check("t2_dout_valid", bus.dout_valid, 1);
    check("t2_digest", bus.digest_o, rep(64'h1));
    handshake();

    // 3: mode 0 on 64-bit lanes clears upper half
    bus.mode = 0; bus.h_in = rep(64'h1_FFFF_FFFF); bus.w_in = rep(64'h1);
    go(); step(4);
    check("t3_digest", bus.digest_o, 0);
    handshake();

    // 4: chaining with SHA-256 IV
    h = {64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
         64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19};
    bus.mode = 0; bus.last_block = 0; bus.h_in = h; bus.w_in = '0;
    go(); step(3);
    check("t4_cv_early", bus.chain_valid, 0);
    step(1);
    check("t4_cv_pulse", bus.chain_valid, 1);
    check("t4_chain_o", bus.chain_o, h);
    check("t4_no_dout", bus.dout_valid, 0);
    step(1);
    check("t4_cv_drop", bus.chain_valid, 0);
    check("t4_busy_drop", bus.busy, 0);
    check("t4_chain_hold", bus.chain_o, h);
    check("t4_no_dout_after", bus.dout_valid, 0);

    // 5: backpressure, distinct words, inputs changed after start
    for (int i = 0; i < 8; i++) begin
      h[(7-i)*64 +: 64] = 64'h0123_4567_89AB_CDEF;
      w[(7-i)*64 +: 64] = 64'(i);
      exp_d[(7-i)*64 +: 64] = 64'h0123_4567_89AB_CDEF + 64'(i);
    end
    bus.mode = 1; bus.last_block = 1; bus.h_in = h; bus.w_in = w;
    go();
    bus.h_in = rep(64'h5555); bus.w_in = rep(64'h7777); bus.mode = 0;
    step(4);
    check("t5_dout_valid", bus.dout_valid, 1);
    check("t5_digest", bus.digest_o, exp_d);
    held = bus.digest_o;
    for (int c = 1; c <= 6; c++) begin
      bus.start = (c == 3);
      step(1);
      check("t5_hold_valid", bus.dout_valid, 1);
      check("t5_hold_digest", bus.digest_o, exp_d);
    end
    bus.start = 1'b1; bus.dout_ready = 1'b1;
    step(1);
    bus.start = 1'b0; bus.dout_ready = 1'b0;
    check("t5_hs_idle", bus.busy, 0);
    step(2);
    check("t5_start_ignored", bus.busy, 0);
    check("t5_result_kept", bus.chain_o, exp_d);

    // 6: reset mid-ADD, then clean rerun
    for (int i = 0; i < 8; i++) begin
      h[(7-i)*64 +: 64] = 64'hDEAD_0000_FFFF_FFFC;
      w[(7-i)*64 +: 64] = 64'(i);
      exp_d[(7-i)*64 +: 64] = {32'h0, 32'hFFFF_FFFC + 32'(i)};
    end
    bus.mode = 0; bus.last_block = 1; bus.h_in = h; bus.w_in = w;
    go(); step(2);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_chain_o", bus.chain_o, 0);
    check("t6_rst_digest", bus.digest_o, 0);
    check("t6_rst_dout_valid", bus.dout_valid, 0);
    step(1);
    rst = 1'b0;
    step(1);
    go(); step(4);
    check("t6_rerun_valid", bus.dout_valid, 1);
    check("t6_rerun_digest", bus.digest_o, exp_d);
    handshake();

    // 7: truncated variants
    for (int i = 0; i < 8; i++) begin
      h[(7-i)*64 +: 64] = 64'h0123_4567_89AB_CDEF;
      w[(7-i)*64 +: 64] = 64'(i);
      exp_d[(7-i)*64 +: 64] = 64'h0123_4567_89AB_CDEF + 64'(i);
    end
    held = exp_d;
`ifdef SHA_TRUNC_EN
    exp_d[127:0] = '0;
`endif
    bus.mode = 1; bus.trunc = 1; bus.h_in = h; bus.w_in = w;
    go(); step(4);
    check("t7_384_digest", bus.digest_o, exp_d);
    check("t7_384_chain", bus.chain_o, held);
    handshake();

    for (int i = 0; i < 8; i++) begin
      h[(7-i)*64 +: 64] = 64'hDEAD_0000_FFFF_FFFC;
      exp_d[(7-i)*64 +: 64] = {32'h0, 32'hFFFF_FFFC + 32'(i)};
    end
    held = exp_d;
`ifdef SHA_TRUNC_EN
    exp_d[63:0] = '0;
`endif
    bus.mode = 0; bus.h_in = h;
    go(); step(4);
    check("t7_224_digest", bus.digest_o, exp_d);
    check("t7_224_chain", bus.chain_o, held);
    handshake();
    bus.trunc = 0;
    check("t7_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
